// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - AES iterative round controller and 128-bit state register
module aes_round_ctrl #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] load_data,
    input  logic [127:0] round_in,
    output logic         mux_sel,
    output logic [127:0] state_out,
    output logic [3:0]   round_idx,
    output logic [7:0]   rcon,
    output logic         last_round,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    localparam logic [3:0] NR_L = 4'(NR);

    fsm_t         state;
    fsm_t         state_nx;
    logic [127:0] state_reg;

    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
    endfunction

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        mux_sel   = 1'b1;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                mux_sel  = 1'b0;
                if (in_valid) state_nx = RUN;
            end
            RUN: begin
                if (round_idx == NR_L) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            state_reg <= '0;
            round_idx <= '0;
            rcon      <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state_reg <= load_data;
                        round_idx <= 4'd1;
                        rcon      <= 8'h01;
                    end
                end
                RUN: begin
                    state_reg <= round_in;
                    // Counters freeze on the final round so DONE still reports round NR.
                    if (round_idx != NR_L) begin
                        round_idx <= round_idx + 4'd1;
                        rcon      <= xtime(rcon);
                    end
                end
                default: ;
            endcase
        end
    end

    assign state_out  = state_reg;
    assign last_round = (state == RUN) && (round_idx == NR_L);
    assign data_out   = (state == DONE) ? state_reg : '0;

endmodule
